// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Asynchronous serial receiver driven by a 16x oversampling tick.
//   It deserialises one frame at a time: a start bit, DBIT data bits sent
//   LSB first, then the stop bit(s). Each bit is sampled at its middle.
//
//   The serial input is first passed through a two-flop synchronizer. Every
//   decision is then made on the synchronized copy, which adds two clocks
//   of latency.
//
// Parameters
//   DBIT     data bits per frame (legal range 5..8)
//   SB_TICK  stop-bit length in oversampling ticks
//            (16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits)
//
// Ports
//   clk           system clock; all logic runs on the rising edge
//   reset_n       asynchronous, active-low reset
//   s_tick        single-cycle oversampling tick, 16 per bit period
//   rx            serial line; idles high; asynchronous to clk
//   dout          last received data word; holds until the next frame
//   rx_done_tick  one-cycle pulse; dout and frame_err are valid with it
//   frame_err     the stop bit was sampled low on the last completed frame
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Tick count at the middle of the start bit; the same count that closes
  // each data-bit window; and the count that closes the stop window.
  localparam logic [4:0] START_MID = 5'd7;
  localparam logic [4:0] DATA_MID  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer. Both flops reset high, which is the idle level of the
  // line, so leaving reset cannot look like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  // NOTE: every clocked block uses non-blocking assignments. Each flop then
  //       samples the value that was present before the edge, so rx_s_q lags
  //       rx_meta_q by a full clock, whatever order the statements are in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [4:0]      s_cnt_q;   // oversampling ticks within the current bit
  logic [2:0]      n_q;       // data bits received so far
  logic [DBIT-1:0] shift_q;   // word being assembled, LSB arrives first
  logic [DBIT-1:0] dout_q;
  logic            done_q;
  logic            frame_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      n_q         <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // The done strobe is high only on the cycle after the closing stop tick.
      done_q <= 1'b0;

      unique case (state_q)
        // Leaving IDLE does not wait for a tick. The tick phase therefore
        // starts at the first low sample of the line, and ticks that arrive
        // while the line is idle are ignored.
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            s_cnt_q <= '0;
          end
        end

        // Check the middle of the start bit again. A line that has already
        // gone back high was a glitch: drop it without producing any output.
        START: begin
          if (s_tick) begin
            if (s_cnt_q == START_MID) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                s_cnt_q <= '0;
                n_q     <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 5'd1;
            end
          end
        end

        // Counting starts at the middle of the start bit. Each window of
        // 16 ticks therefore ends in the middle of the next data bit.
        DATA: begin
          if (s_tick) begin
            if (s_cnt_q == DATA_MID) begin
              s_cnt_q <= '0;
              shift_q <= {rx_s_q, shift_q[DBIT-1:1]};
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + 3'd1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 5'd1;
            end
          end
        end

        // The stop level is sampled at the end of its window. The word is
        // published even when framing fails. A line held low (break) then
        // re-enters START from IDLE on the next clock, so it cannot lock up.
        STOP: begin
          if (s_tick) begin
            if (s_cnt_q == STOP_LAST) begin
              state_q     <= IDLE;
              s_cnt_q     <= '0;
              dout_q      <= shift_q;
              frame_err_q <= ~rx_s_q;
              done_q      <= 1'b1;
            end else begin
              s_cnt_q <= s_cnt_q + 5'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = frame_err_q;

endmodule
